// File: rtl/sprite_cfg_ctrl.sv
// sprite_cfg_ctrl
// Serial configuration controller for the single-sprite SVGA renderer.
// A 2-wire SPI stream (no chip-select) is framed into an address byte
// followed by a burst of data bytes, using an idle timeout to reframe.
// The data bytes fill a shadow register file. The renderer-facing copy is
// refreshed from the shadow only on next_frame, so the sprite never tears.
//
// Ports:
//   clk            system (pixel) clock
//   reset          asynchronous, active-high reset
//   spi_clk        serial clock, asynchronous to clk (max clk/8)
//   spi_data       serial data, sampled on spi_clk rising edge, MSB first
//   next_frame     one-cycle pulse at start of vertical blank (commit point)
//   bg_color       active background RRGGBB
//   fg_color       active sprite RRGGBB
//   sprite_x       active sprite left column
//   sprite_y       active sprite top line
//   sprite_bitmap  active 8x8 bitmap, row r = [8r+7:8r], bit 7 = leftmost
//   update_pending shadow written since last commit
//   frame_active   SPI transaction in progress
//
// Build option:
//   SPRITE_CFG_NOSHADOW_EN  writes land directly in the active registers,
//                           next_frame is ignored, update_pending is 0.
module sprite_cfg_ctrl #(
    parameter int unsigned IDLE_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_clk,
    input  logic        spi_data,
    input  logic        next_frame,
    output logic [5:0]  bg_color,
    output logic [5:0]  fg_color,
    output logic [9:0]  sprite_x,
    output logic [9:0]  sprite_y,
    output logic [63:0] sprite_bitmap,
    output logic        update_pending,
    output logic        frame_active
);

    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);

    typedef enum logic {
        ADDR,
        DATA
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and rising-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   rise;
    logic                   bit_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '0;
            data_sync <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign rise   = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign bit_in = data_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Idle timeout
    // ------------------------------------------------------------------
    logic [IDLE_W-1:0] idle_cnt;
    logic              timeout;

    assign timeout = (idle_cnt == IDLE_W'(IDLE_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (rise) begin
            idle_cnt <= '0;
        end else if (!timeout) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Byte framing
    // ------------------------------------------------------------------
    logic [6:0] shift_reg;
    logic [2:0] bit_cnt;
    logic [7:0] byte_in;
    logic       byte_done;

    // The completed byte includes the bit arriving on this strobe.
    assign byte_in   = {shift_reg, bit_in};
    assign byte_done = rise && (bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            frame_active <= 1'b0;
        end else if (rise) begin
            shift_reg    <= byte_in[6:0];
            bit_cnt      <= bit_cnt + 3'd1;
            frame_active <= 1'b1;
        end else if (timeout) begin
            // Partial byte is dropped here.
            bit_cnt      <= '0;
            frame_active <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Address / data FSM
    // ------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic       addr_load;
    logic       wr_en;
    logic       reg_hit;
    logic [7:0] addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ADDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_load = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            ADDR: begin
                if (byte_done) begin
                    addr_load = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (byte_done) begin
                    wr_en = 1'b1;
                end
            end
            default: state_d = ADDR;
        endcase
        if (!rise && timeout) begin
            state_d = ADDR;
        end
    end

    // Only 0x00-0x05 and 0x08-0x0F hold state.
    assign reg_hit = wr_en && (addr_q[7:4] == 4'h0) && (addr_q[3:1] != 3'b011);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (addr_load) begin
            addr_q <= byte_in;
        end else if (wr_en) begin
            addr_q <= addr_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Shadow register file
    // ------------------------------------------------------------------
    logic [5:0]  sh_bg;
    logic [5:0]  sh_fg;
    logic [9:0]  sh_x;
    logic [9:0]  sh_y;
    logic [63:0] sh_bm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_bg <= '0;
            sh_fg <= '1;
            sh_x  <= '0;
            sh_y  <= '0;
            sh_bm <= '0;
        end else if (reg_hit) begin
            case (addr_q[3:0])
                4'h0:    sh_bg       <= byte_in[5:0];
                4'h1:    sh_fg       <= byte_in[5:0];
                4'h2:    sh_x[7:0]   <= byte_in;
                4'h3:    sh_x[9:8]   <= byte_in[1:0];
                4'h4:    sh_y[7:0]   <= byte_in;
                4'h5:    sh_y[9:8]   <= byte_in[1:0];
                default: sh_bm[{addr_q[2:0], 3'b000} +: 8] <= byte_in;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Active copy
    // ------------------------------------------------------------------
`ifdef SPRITE_CFG_NOSHADOW_EN
    logic unused_next_frame;
    assign unused_next_frame = next_frame;

    assign bg_color       = sh_bg;
    assign fg_color       = sh_fg;
    assign sprite_x       = sh_x;
    assign sprite_y       = sh_y;
    assign sprite_bitmap  = sh_bm;
    assign update_pending = 1'b0;
`else
    logic commit;

    assign commit = next_frame && update_pending;

    // A write landing in the commit cycle is not copied (non-blocking
    // shadow update), so pending must survive for the next commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bg_color       <= '0;
            fg_color       <= '1;
            sprite_x       <= '0;
            sprite_y       <= '0;
            sprite_bitmap  <= '0;
            update_pending <= 1'b0;
        end else begin
            if (commit) begin
                bg_color      <= sh_bg;
                fg_color      <= sh_fg;
                sprite_x      <= sh_x;
                sprite_y      <= sh_y;
                sprite_bitmap <= sh_bm;
            end
            if (reg_hit) begin
                update_pending <= 1'b1;
            end else if (commit) begin
                update_pending <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sprite_cfg_ctrl.sv
// Testbench for sprite_cfg_ctrl: table of single-register frames plus
// hand-written sequences for reset, bursts, timeout and commit collision.
module tb_sprite_cfg_ctrl;

    localparam int unsigned TB_IDLE = 64;
    localparam int unsigned TB_SYNC = 2;

    logic        clk;
    logic        reset;
    logic        spi_clk;
    logic        spi_data;
    logic        next_frame;
    logic [5:0]  bg_color;
    logic [5:0]  fg_color;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic [63:0] sprite_bitmap;
    logic        update_pending;
    logic        frame_active;

    sprite_cfg_ctrl #(
        .IDLE_CYCLES(TB_IDLE),
        .SYNC_STAGES(TB_SYNC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .spi_clk       (spi_clk),
        .spi_data      (spi_data),
        .next_frame    (next_frame),
        .bg_color      (bg_color),
        .fg_color      (fg_color),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y),
        .sprite_bitmap (sprite_bitmap),
        .update_pending(update_pending),
        .frame_active  (frame_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  bg;
        logic [5:0]  fg;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [63:0] bm;
        logic        pend;
        logic        fa;
    } snap_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        pend;
        logic [5:0]  bg;
        logic [5:0]  fg;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [63:0] bm;
    } vec_t;

    int    n_vec;
    int    n_miss;
    snap_t exp_q[$];
    snap_t model;
    snap_t exp_s;
    vec_t  tbl[10];

    function automatic snap_t dut_snap();
        return {bg_color, fg_color, sprite_x, sprite_y, sprite_bitmap,
                update_pending, frame_active};
    endfunction

    task automatic check(input string name, input snap_t act, input snap_t exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got bg=%h fg=%h x=%h y=%h bm=%h pend=%b fa=%b, expected bg=%h fg=%h x=%h y=%h bm=%h pend=%b fa=%b",
                     name, act.bg, act.fg, act.x, act.y, act.bm, act.pend, act.fa,
                     exp.bg, exp.fg, exp.x, exp.y, exp.bm, exp.pend, exp.fa);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            spi_data = b[7-i];
            spi_clk  = 1'b0;
            repeat (4) @(negedge clk);
            spi_clk  = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic wait_idle();
        repeat (TB_IDLE + 8) @(negedge clk);
    endtask

    // Pulse next_frame with the expected post-commit state queued.
    task automatic commit_and_check(input string name, input snap_t exp);
        exp_q.push_back(exp);
        next_frame = 1'b1;
        @(negedge clk);
        next_frame = 1'b0;
        check(name, dut_snap(), exp_q.pop_front());
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        reset      = 1'b1;
        spi_clk    = 1'b0;
        spi_data   = 1'b0;
        next_frame = 1'b0;

        //                addr   data   pend  bg     fg     x       y       bitmap
        tbl[0] = {8'h00, 8'h15, 1'b1, 6'h15, 6'h3F, 10'h000, 10'h000, 64'h0};
        tbl[1] = {8'h01, 8'h11, 1'b1, 6'h15, 6'h11, 10'h000, 10'h000, 64'h0};
        tbl[2] = {8'h02, 8'hC5, 1'b1, 6'h15, 6'h11, 10'h0C5, 10'h000, 64'h0};
        tbl[3] = {8'h03, 8'hFE, 1'b1, 6'h15, 6'h11, 10'h2C5, 10'h000, 64'h0};
        tbl[4] = {8'h05, 8'h03, 1'b1, 6'h15, 6'h11, 10'h2C5, 10'h300, 64'h0};
        tbl[5] = {8'h04, 8'h7F, 1'b1, 6'h15, 6'h11, 10'h2C5, 10'h37F, 64'h0};
        tbl[6] = {8'h06, 8'hFF, 1'b0, 6'h15, 6'h11, 10'h2C5, 10'h37F, 64'h0};
        tbl[7] = {8'h10, 8'h12, 1'b0, 6'h15, 6'h11, 10'h2C5, 10'h37F, 64'h0};
        tbl[8] = {8'h0F, 8'hA5, 1'b1, 6'h15, 6'h11, 10'h2C5, 10'h37F, 64'hA500_0000_0000_0000};
        tbl[9] = {8'h00, 8'hC0, 1'b1, 6'h00, 6'h11, 10'h2C5, 10'h37F, 64'hA500_0000_0000_0000};

        model = {6'h00, 6'h3F, 10'h000, 10'h000, 64'h0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_state", dut_snap(), model);

        // Mid-byte reset: a pending shadow write and a partial byte are lost.
        send_byte(8'h01);
        send_byte(8'h07);
        wait_idle();
        exp_s      = model;
        exp_s.pend = 1'b1;
        check("pend_before_reset", dut_snap(), exp_s);
        send_bits(8'h00, 3);
        exp_s.fa = 1'b1;
        check("active_mid_byte", dut_snap(), exp_s);
        spi_clk = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", dut_snap(), model);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("after_reset", dut_snap(), model);

        // Table of single-register frames, each committed separately.
        for (int i = 0; i < 10; i++) begin
            send_byte(tbl[i].addr);
            send_byte(tbl[i].data);
            wait_idle();
            exp_s      = model;
            exp_s.pend = tbl[i].pend;
            check($sformatf("vec%0d_pre", i), dut_snap(), exp_s);
            model = {tbl[i].bg, tbl[i].fg, tbl[i].x, tbl[i].y, tbl[i].bm, 1'b0, 1'b0};
            commit_and_check($sformatf("vec%0d_commit", i), model);
        end

        // Bitmap burst with auto-increment.
        send_byte(8'h08);
        send_byte(8'h81); send_byte(8'h42); send_byte(8'h24); send_byte(8'h18);
        send_byte(8'h18); send_byte(8'h24); send_byte(8'h42); send_byte(8'h81);
        wait_idle();
        model.bm = 64'h8142_2418_1824_4281;
        commit_and_check("bitmap_burst", model);

        // Position burst running into a reserved address.
        send_byte(8'h02);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h34);
        send_byte(8'h01); send_byte(8'hAA);
        wait_idle();
        model.x = 10'h3FF;
        model.y = 10'h134;
        commit_and_check("pos_burst", model);

        // Partial byte followed by timeout, then a clean frame.
        send_bits(8'hFF, 5);
        exp_s    = model;
        exp_s.fa = 1'b1;
        check("partial_active", dut_snap(), exp_s);
        repeat (TB_IDLE + 8) @(negedge clk);
        check("timeout_gap", dut_snap(), model);
        send_byte(8'h01);
        send_byte(8'h3C);
        wait_idle();
        model.fg = 6'h3C;
        commit_and_check("after_timeout", model);

        // Write landing in the same cycle as next_frame.
        send_byte(8'h01);
        send_byte(8'h05);
        wait_idle();
        send_byte(8'h00);
        send_bits(8'h2A, 7);
        spi_data = 1'b0;
        spi_clk  = 1'b0;
        repeat (4) @(negedge clk);
        spi_clk  = 1'b1;
        repeat (TB_SYNC) @(negedge clk);
        model.fg   = 6'h05;
        exp_s      = model;
        exp_s.pend = 1'b1;
        exp_s.fa   = 1'b1;
        commit_and_check("collide_commit", exp_s);
        wait_idle();
        model.bg = 6'h2A;
        commit_and_check("collide_next", model);

        // No pending update: next_frame changes nothing.
        commit_and_check("idle_commit", model);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sprite_cfg_ctrl.md
Name: sprite_cfg_ctrl

Overview:
Serial configuration controller for the single-sprite SVGA renderer.
- Receives 2-wire SPI (spi_clk, spi_data, no chip-select) from the chip pins.
- Frames it into address/data bytes, using an idle timeout for framing.
- Writes a shadow register file holding background/foreground colour, sprite position and 8x8 1bpp bitmap.
- Commits the shadow file to the renderer-facing active copy only on the next_frame pulse, so no tearing.

Parameters:
IDLE_CYCLES, 1024, clk cycles with no spi_clk rising edge before the transaction is aborted/reframed (>=16)
SYNC_STAGES, 2, synchroniser flops on spi_clk/spi_data (>=2)

Ports:
clk  input  1  system (pixel) clock
reset  input  1  asynchronous, active-high reset
spi_clk  input  1  serial clock, asynchronous to clk, max clk/8
spi_data  input  1  serial data, sampled on spi_clk rising edge, MSB first
next_frame  input  1  one-cycle pulse from timing generator at start of vertical blank
bg_color  output  6  active background RRGGBB
fg_color  output  6  active sprite RRGGBB
sprite_x  output  10  active sprite left column
sprite_y  output  10  active sprite top line
sprite_bitmap  output  64  active bitmap; row r = bits [8r+7:8r], bit 7 = leftmost pixel
update_pending  output  1  shadow differs (written) since last commit
frame_active  output  1  SPI transaction in progress (at least one edge seen, not timed out)

Behaviour:
- Reset (async, any time, including mid-byte): all outputs and shadow regs take reset values.
  - bg=0, fg=6'h3F, x=0, y=0, bitmap=0, update_pending=0, frame_active=0.
  - FSM goes to ADDR, bit count 0, idle counter 0.
- Input path: spi_clk/spi_data pass through SYNC_STAGES flops, plus one edge-detect flop. A rise strobe fires one cycle per sync'd rising edge. On the strobe, the sync'd data bit is shifted into an 8-bit shift register, MSB first.
- Idle counter:
  - Cleared on each rise strobe; otherwise increments, saturating at IDLE_CYCLES.
  - On reaching IDLE_CYCLES: bit count cleared, FSM goes to ADDR, frame_active=0.
  - Partial bytes are discarded; no register is written.
- frame_active is set on the first rise strobe after ADDR entry.
- FSM:
  - ADDR: on the 8th strobe, the byte is loaded into the 8-bit address reg; go to DATA.
  - DATA: on each 8th strobe, write the shadow reg at address, then address+1, wrapping 0xFF->0x00. Stay in DATA until timeout.
- Register map (shadow):
  - 0x00 bg[5:0]
  - 0x01 fg[5:0]
  - 0x02 x[7:0]
  - 0x03 x[9:8] from data[1:0]
  - 0x04 y[7:0]
  - 0x05 y[9:8]
  - 0x06-0x07 reserved
  - 0x08-0x0F bitmap row 0-7
  - Unused data bits are ignored. Writes to reserved or >=0x10 are discarded but still increment the address and do not set update_pending.
- Write timing: a write completing on the strobe in cycle N is visible in the shadow at N+1. update_pending is set at N+1.
- Commit: next_frame high in cycle M with update_pending=1 means all active regs = shadow at M+1, and update_pending=0 at M+1. With update_pending=0, next_frame has no effect.
- Simultaneous valid write and next_frame in the same cycle: the commit copies the pre-write shadow, and update_pending stays 1, so the write is applied at the following next_frame.
- next_frame held high for several cycles: each cycle behaves as a separate pulse.
- Active outputs are registered and change only at reset or commit.

Optional Feature:
SPRITE_CFG_NOSHADOW_EN
- Defined: shadow file is removed; writes go directly to the active regs, visible at N+1. next_frame is ignored and update_pending is tied 0. Used for bring-up/debug; tearing is allowed.
- Undefined: double-buffered behaviour as above (default for tapeout).

Test Plan:
1. Assert reset mid-byte (after 3 bits), release -> bg=0, fg=0x3F, x=y=0, bitmap=0, update_pending=0, frame_active=0; next full frame decodes correctly from ADDR.
2. Send bytes 0x00,0x15, then idle -> update_pending=1, bg still 0; pulse next_frame -> bg=0x15 next cycle, update_pending=0.
3. Burst 0x08, then 0x81,0x42,0x24,0x18,0x18,0x24,0x42,0x81; pulse next_frame -> sprite_bitmap=64'h8142241818244281.
4. Send 0x02,0xFF,0xFF,0x34,0x01,0xAA; commit -> sprite_x=0x3FF, sprite_y=0x134, 0x06 write ignored, other regs unchanged.
5. Send 5 bits, wait IDLE_CYCLES+2, then 0x01,0x3C; commit -> fg=0x3C, bg unchanged, frame_active low during the gap.
6. Align the 8th-bit strobe of data 0x2A (address 0x00) with a next_frame pulse -> bg unchanged that frame, update_pending=1; next pulse -> bg=0x2A.
